// File: rtl/activation_arbiter_if.sv
// Requester-side and unit-side handshake bundle for the shared activation arbiter.
// slave = arbiter view, master = neuron array plus activation unit view.
interface activation_arbiter_if #(
   parameter int unsigned N    = 3,
   parameter int unsigned ARGW = 16,
   parameter int unsigned RESW = 8,
   parameter int unsigned ERRW = 16,
   parameter int unsigned FBKW = 16
);
   logic [N-1:0]      req_train;
   logic [N-1:0]      req_arg_valid;
   logic [N-1:0]      req_arg_ready;
   logic [N*ARGW-1:0] req_arg_data;
   logic [N-1:0]      req_res_valid;
   logic [N-1:0]      req_res_ready;
   logic [RESW-1:0]   req_res_data;
   logic [N-1:0]      req_err_valid;
   logic [N-1:0]      req_err_ready;
   logic [N*ERRW-1:0] req_err_data;
   logic [N-1:0]      req_fbk_valid;
   logic [N-1:0]      req_fbk_ready;
   logic [FBKW-1:0]   req_fbk_data;

   logic              arg_valid;
   logic [ARGW-1:0]   arg_data;
   logic              arg_ready;
   logic              res_valid;
   logic [RESW-1:0]   res_data;
   logic              res_ready;
   logic              err_valid;
   logic [ERRW-1:0]   err_data;
   logic              err_ready;
   logic              fbk_valid;
   logic [FBKW-1:0]   fbk_data;
   logic              fbk_ready;

   modport slave (
      input  req_train, req_arg_valid, req_arg_data, req_res_ready,
             req_err_valid, req_err_data, req_fbk_ready,
             arg_ready, res_valid, res_data, err_ready, fbk_valid, fbk_data,
      output req_arg_ready, req_res_valid, req_res_data, req_err_ready,
             req_fbk_valid, req_fbk_data,
             arg_valid, arg_data, res_ready, err_valid, err_data, fbk_ready
   );

   modport master (
      output req_train, req_arg_valid, req_arg_data, req_res_ready,
             req_err_valid, req_err_data, req_fbk_ready,
             arg_ready, res_valid, res_data, err_ready, fbk_valid, fbk_data,
      input  req_arg_ready, req_res_valid, req_res_data, req_err_ready,
             req_fbk_valid, req_fbk_data,
             arg_valid, arg_data, res_ready, err_valid, err_data, fbk_ready
   );
endinterface

// File: rtl/activation_arbiter.sv
// Round-robin arbiter sharing one activation unit among N requesters; the grant
// is held across the forward pass and, when training, the backward pass.
module activation_arbiter #(
   parameter int unsigned N    = 3,
   parameter int unsigned ARGW = 16,
   parameter int unsigned RESW = 8,
   parameter int unsigned ERRW = 16,
   parameter int unsigned FBKW = 16,
   parameter int unsigned IDXW = $clog2(N)
) (
   input  logic                 clk,
   input  logic                 rst,
   activation_arbiter_if.slave  bus,
   output logic                 en,
   output logic [IDXW-1:0]      grant,
   output logic                 busy
);

   typedef enum logic [2:0] {S_IDLE, S_ARG, S_RES, S_ERR, S_FBK} state_t;

   state_t          state_q, state_d;
   logic [IDXW-1:0] ptr_q, ptr_d;
   logic [IDXW-1:0] grant_q, grant_d;
   logic            en_q, en_d;

   logic [N-1:0]    gmask;
   logic [IDXW-1:0] ptr_next;
   logic [IDXW-1:0] sel_idx;
   logic            sel_found;
   int unsigned     cand;

   assign gmask    = N'(1) << grant_q;
   assign ptr_next = (grant_q == IDXW'(N - 1)) ? '0 : grant_q + IDXW'(1);

   // Data paths are pure muxes/broadcasts; only the handshakes are state-gated.
   assign bus.arg_data     = bus.req_arg_data[32'(grant_q) * ARGW +: ARGW];
   assign bus.err_data     = bus.req_err_data[32'(grant_q) * ERRW +: ERRW];
   assign bus.req_res_data = RESW'(bus.res_data);
   assign bus.req_fbk_data = FBKW'(bus.fbk_data);

   // First requesting index at or above ptr, wrapping at N (N need not be 2^k).
   always_comb begin
      sel_found = 1'b0;
      sel_idx   = '0;
      cand      = 0;
      for (int unsigned i = 0; i < N; i++) begin
         cand = 32'(ptr_q) + i;
         if (cand >= N) cand = cand - N;
         if (!sel_found && bus.req_arg_valid[cand]) begin
            sel_found = 1'b1;
            sel_idx   = IDXW'(cand);
         end
      end
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      grant_d = grant_q;
      en_d    = en_q;

      bus.req_arg_ready = '0;
      bus.req_res_valid = '0;
      bus.req_err_ready = '0;
      bus.req_fbk_valid = '0;
      bus.arg_valid     = 1'b0;
      bus.res_ready     = 1'b0;
      bus.err_valid     = 1'b0;
      bus.fbk_ready     = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (sel_found) begin
               grant_d = sel_idx;
               en_d    = bus.req_train[sel_idx];
               state_d = S_ARG;
            end
         end
         S_ARG: begin
            bus.arg_valid     = |(bus.req_arg_valid & gmask);
            bus.req_arg_ready = gmask & {N{bus.arg_ready}};
            if (|(bus.req_arg_valid & gmask) && bus.arg_ready) state_d = S_RES;
         end
         S_RES: begin
            bus.req_res_valid = gmask & {N{bus.res_valid}};
            bus.res_ready     = |(bus.req_res_ready & gmask);
            if (bus.res_valid && |(bus.req_res_ready & gmask)) begin
               if (en_q) begin
                  state_d = S_ERR;
               end else begin
                  state_d = S_IDLE;
                  ptr_d   = ptr_next;
               end
            end
         end
         S_ERR: begin
            bus.err_valid     = |(bus.req_err_valid & gmask);
            bus.req_err_ready = gmask & {N{bus.err_ready}};
            if (|(bus.req_err_valid & gmask) && bus.err_ready) state_d = S_FBK;
         end
         S_FBK: begin
            bus.req_fbk_valid = gmask & {N{bus.fbk_valid}};
            bus.fbk_ready     = |(bus.req_fbk_ready & gmask);
            if (bus.fbk_valid && |(bus.req_fbk_ready & gmask)) begin
               state_d = S_IDLE;
               ptr_d   = ptr_next;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         ptr_q   <= '0;
         grant_q <= '0;
         en_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         grant_q <= grant_d;
         en_q    <= en_d;
      end
   end

   assign en    = en_q;
   assign grant = grant_q;
   assign busy  = (state_q != S_IDLE);

endmodule
